mem_arbiter: RTL and testbench

Four-port arbiter between the per-processor memory interfaces and the shared `memory_subsystem`. It grants exactly one requester at a time using round-robin priority. It registers the winner's address, write data and operation, drives the single downstream read/write handshake, and returns read data and completion to the granted port. A timeout guards against a memory that never acknowledges.

---
 rtl/tinyalu_pkg.sv | 19 +
 rtl/mem_arbiter_rr_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the memory arbiter.
package tinyalu_pkg;

  // Arbiter FSM: wait for a requester, run one memory access, report completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ARB_NPORT           = 4;
  localparam int ARB_TIMEOUT_DEFAULT = 255;

  // One-hot encoding of a 2-bit port index.
  function automatic logic [ARB_NPORT-1:0] port_onehot(input logic [1:0] idx);
    port_onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first active port after the last winner.
module rr_pick
  import tinyalu_pkg::*;
(
  input  logic [ARB_NPORT-1:0] active,
  input  logic [1:0]           last,
  output logic                 any,
  output logic [1:0]           idx
);

  logic [1:0] cand_s;
  logic       hit_s;

  // Walk one full rotation starting at last+1; the first active port found wins.
  always_comb begin
    any    = 1'b0;
    idx    = 2'd0;
    cand_s = 2'd0;
    hit_s  = 1'b0;
    for (int i = 1; i <= ARB_NPORT; i++) begin
      cand_s = last + 2'(i);
      hit_s  = ~any & active[cand_s];
      idx    = hit_s ? cand_s : idx;
      any    = any | active[cand_s];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Four-port round-robin arbiter in front of the shared memory subsystem.
// One transaction at a time: latch the winner, drive the downstream request
// until ack or timeout, then pulse done/err back to the granted port.
module mem_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NPORT   = ARB_NPORT,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NPORT-1:0]        rd_req,
  input  logic [NPORT-1:0]        wr_req,
  input  logic [NPORT*ADDR_W-1:0] addr_in,
  input  logic [NPORT*DATA_W-1:0] wdata_in,
  output logic [NPORT-1:0]        grant,
  output logic [NPORT-1:0]        done,
  output logic                    err,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic                    mem_read_req,
  output logic                    mem_write_req,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_write_data,
  input  logic [DATA_W-1:0]       mem_read_data,
  input  logic                    mem_ack
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  arb_state_t         state_r;
  logic [1:0]         last_r;
  logic [1:0]         idx_r;
  logic               bad_op_r;
  logic [7:0]         cnt_r;

  logic [NPORT-1:0]   active_s;
  logic               any_s;
  logic [1:0]         pick_s;
  logic               pick_rd_s;
  logic               pick_wr_s;
  logic [ADDR_W-1:0]  pick_addr_s;
  logic [DATA_W-1:0]  pick_wdata_s;

  assign active_s = rd_req | wr_req;

  rr_pick u_rr_pick (
    .active (active_s),
    .last   (last_r),
    .any    (any_s),
    .idx    (pick_s)
  );

  // Route the candidate winner's request fields out of the packed port buses.
  always_comb begin
    pick_rd_s    = rd_req[pick_s];
    pick_wr_s    = wr_req[pick_s];
    pick_addr_s  = addr_in[int'(pick_s)*ADDR_W +: ADDR_W];
    pick_wdata_s = wdata_in[int'(pick_s)*DATA_W +: DATA_W];
  end

  // Transaction FSM with registered grant, downstream handshake and completion outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      last_r         <= 2'd3;
      idx_r          <= 2'd0;
      bad_op_r       <= 1'b0;
      cnt_r          <= 8'd0;
      grant          <= {NPORT{1'b0}};
      done           <= {NPORT{1'b0}};
      err            <= 1'b0;
      rdata          <= {DATA_W{1'b0}};
      busy           <= 1'b0;
      mem_read_req   <= 1'b0;
      mem_write_req  <= 1'b0;
      mem_addr       <= {ADDR_W{1'b0}};
      mem_write_data <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            // A write request dominates; rd+wr together is flagged as a bad op.
            idx_r          <= pick_s;
            grant          <= port_onehot(pick_s);
            mem_addr       <= pick_addr_s;
            mem_write_data <= pick_wdata_s;
            mem_write_req  <= pick_wr_s;
            mem_read_req   <= ~pick_wr_s;
            bad_op_r       <= pick_wr_s & pick_rd_s;
            cnt_r          <= 8'd0;
            busy           <= 1'b1;
            state_r        <= BUSY;
          end
        end
        BUSY: begin
          // Ack is checked first so an ack on the final timeout cycle still succeeds.
          if (mem_ack) begin
            if (mem_read_req) begin
              rdata <= mem_read_data;
            end
            done          <= grant;
            err           <= bad_op_r;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            state_r       <= RESP;
          end else if (cnt_r == TIMEOUT_C) begin
            done          <= grant;
            err           <= 1'b1;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            state_r       <= RESP;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        RESP: begin
          last_r   <= idx_r;
          done     <= {NPORT{1'b0}};
          err      <= 1'b0;
          grant    <= {NPORT{1'b0}};
          bad_op_r <= 1'b0;
          cnt_r    <= 8'd0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          done          <= {NPORT{1'b0}};
          err           <= 1'b0;
          grant         <= {NPORT{1'b0}};
          busy          <= 1'b0;
          mem_read_req  <= 1'b0;
          mem_write_req <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic, checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  rd_req, wr_req;
  logic [55:0] addr_in;
  logic [63:0] wdata_in;
  logic [3:0]  grant, done;
  logic        err, busy, mem_read_req, mem_write_req, mem_ack;
  logic [15:0] rdata, mem_write_data, mem_read_data;
  logic [13:0] mem_addr;

  mem_arbiter #(.NPORT(4), .ADDR_W(14), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .wr_req(wr_req),
    .addr_in(addr_in), .wdata_in(wdata_in), .grant(grant), .done(done),
    .err(err), .rdata(rdata), .busy(busy), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: transaction phase counted in cycles since grant rose.
  int          cyc, exp_done, ack_at, ack_mode, req_mode, model_last, win;
  bit          start, noise_en, drop_en, data_fixed_en;
  logic        win_wr, win_bad, exp_err, last_done_err;
  logic [13:0] win_addr;
  logic [15:0] win_wdata, model_rdata, data_fixed;
  logic [3:0]  dut_grants[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_grant"}, 64'(grant), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
    check_eq({tag, "_err"}, 64'(err), 64'd0);
    check_eq({tag, "_rdata"}, 64'(rdata), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_memreq"}, 64'({mem_read_req, mem_write_req}), 64'd0);
    check_eq({tag, "_maddr"}, 64'(mem_addr), 64'd0);
    check_eq({tag, "_mwdata"}, 64'(mem_write_data), 64'd0);
  endtask

  // One clock cycle: pick next winner if idle, check outputs, then drive inputs.
  task automatic step();
    logic [3:0] act, oh;
    bit found, acked;
    if (cyc == 0 && !start) begin
      act = rd_req | wr_req;
      if (act != 4'b0000) begin
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
          if (!found && act[(model_last + i) % 4]) begin
            found = 1'b1;
            win = (model_last + i) % 4;
          end
        end
        win_wr    = wr_req[win];
        win_bad   = wr_req[win] & rd_req[win];
        win_addr  = addr_in[win*14 +: 14];
        win_wdata = wdata_in[win*16 +: 16];
        ack_at    = (ack_mode < 0) ? int'($urandom_range(0, 6)) : ack_mode;
        acked     = (ack_at >= 1) && (ack_at <= TMO + 1);
        exp_done  = acked ? ack_at + 1 : TMO + 2;
        exp_err   = win_bad | ~acked;
        start     = 1'b1;
      end
    end
    @(negedge clk);
    if (start) begin
      cyc = 1;
      start = 1'b0;
      dut_grants.push_back(grant);
    end else if (cyc > 0 && cyc == exp_done) begin
      cyc = 0;
      model_last = win;
    end else if (cyc > 0) begin
      cyc++;
    end
    oh = 4'b0001 << win;
    if (cyc == 0) begin
      check_eq("grant_idle", 64'(grant), 64'd0);
      check_eq("done_idle", 64'(done), 64'd0);
      check_eq("busy_idle", 64'(busy), 64'd0);
      check_eq("memreq_idle", 64'({mem_read_req, mem_write_req}), 64'd0);
    end else if (cyc < exp_done) begin
      check_eq("grant_busy", 64'(grant), 64'(oh));
      check_eq("done_busy", 64'(done), 64'd0);
      check_eq("busy_busy", 64'(busy), 64'd1);
      check_eq("memreq_busy", 64'({mem_read_req, mem_write_req}), 64'({~win_wr, win_wr}));
      check_eq("maddr_busy", 64'(mem_addr), 64'(win_addr));
      check_eq("mwdata_busy", 64'(mem_write_data), 64'(win_wdata));
    end else begin
      check_eq("grant_resp", 64'(grant), 64'(oh));
      check_eq("done_resp", 64'(done), 64'(oh));
      check_eq("err_resp", 64'(err), 64'(exp_err));
      check_eq("rdata_resp", 64'(rdata), 64'(model_rdata));
      check_eq("busy_resp", 64'(busy), 64'd1);
      check_eq("memreq_resp", 64'({mem_read_req, mem_write_req}), 64'd0);
      last_done_err = err;
    end
    // Memory responder.
    mem_ack = 1'b0;
    mem_read_data = 16'($urandom);
    if (cyc > 0 && cyc < exp_done && cyc == ack_at) begin
      mem_ack = 1'b1;
      if (data_fixed_en) mem_read_data = data_fixed;
      if (!win_wr) model_rdata = mem_read_data;
    end else if (noise_en && (cyc == 0 || cyc >= exp_done)) begin
      mem_ack = ($urandom_range(0, 3) == 0);
    end
    // Requesters.
    if (cyc > 0 && cyc == exp_done) begin
      rd_req[win] = 1'b0;
      wr_req[win] = 1'b0;
    end else if (drop_en && cyc > 0 && $urandom_range(0, 7) == 0) begin
      rd_req[win] = 1'b0;
      wr_req[win] = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      if (!(rd_req[p] | wr_req[p]) && !(cyc > 0 && p == win)) begin
        if (req_mode == 2) begin
          rd_req[p] = 1'b1;
          addr_in[p*14 +: 14] = 14'($urandom);
        end else if (req_mode == 1 && $urandom_range(0, 3) == 0) begin
          automatic int r = int'($urandom_range(0, 9));
          wr_req[p] = (r <= 4);
          rd_req[p] = (r == 0) || (r >= 5);
          addr_in[p*14 +: 14] = 14'($urandom);
          wdata_in[p*16 +: 16] = 16'($urandom);
        end
      end
    end
  endtask

  task automatic run_until_idle(input int max_steps);
    automatic int n = 0;
    req_mode = 0;
    while ((cyc != 0 || start || (rd_req | wr_req) != 4'b0000) && n < max_steps) begin
      step();
      n++;
    end
    check_eq("drain_bound", 64'(n < max_steps), 64'd1);
  endtask

  initial begin
    #150000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int n;
    reset_n = 1'b0; rd_req = 4'b0000; wr_req = 4'b0000;
    addr_in = 56'd0; wdata_in = 64'd0; mem_ack = 1'b0; mem_read_data = 16'd0;
    cyc = 0; start = 1'b0; model_last = 3; model_rdata = 16'd0; win = 0;
    exp_done = 0; ack_at = 0; ack_mode = 2; req_mode = 0;
    noise_en = 1'b0; drop_en = 1'b0; data_fixed_en = 1'b0; data_fixed = 16'd0;
    last_done_err = 1'b0;
    @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;

    // Round-robin: all ports request continuously from reset.
    rd_req = 4'hF;
    req_mode = 2; ack_mode = 2; n = 0;
    while (dut_grants.size() < 5 && n < 100) begin step(); n++; end
    run_until_idle(100);
    for (int k = 0; k < 5; k++)
      check_eq("rr_order", 64'((k < dut_grants.size()) ? dut_grants[k] : 4'b0000),
               64'(4'b0001 << rr_exp[k]));

    // Single read on port 2.
    dut_grants.delete();
    ack_mode = 3; data_fixed_en = 1'b1; data_fixed = 16'hBEEF;
    addr_in[2*14 +: 14] = 14'h0123; rd_req[2] = 1'b1;
    step();
    check_eq("sr_addr", 64'(mem_addr), 64'h0123);
    check_eq("sr_rdreq", 64'(mem_read_req), 64'd1);
    run_until_idle(50);
    check_eq("sr_rdata", 64'(rdata), 64'hBEEF);
    check_eq("sr_err", 64'(last_done_err), 64'd0);
    check_eq("sr_grant", 64'((dut_grants.size() > 0) ? dut_grants[0] : 4'b0000), 64'h4);

    // Port 1 write while port 3 waits with a read.
    dut_grants.delete();
    ack_mode = 2;
    addr_in[1*14 +: 14] = 14'h0010; wdata_in[1*16 +: 16] = 16'h5A5A; wr_req[1] = 1'b1;
    step();
    addr_in[3*14 +: 14] = 14'h2222; rd_req[3] = 1'b1;
    check_eq("wc_wdata", 64'(mem_write_data), 64'h5A5A);
    check_eq("wc_wreq", 64'(mem_write_req), 64'd1);
    step();
    check_eq("wc_g3", 64'(grant[3]), 64'd0);
    run_until_idle(60);
    check_eq("wc_g0", 64'((dut_grants.size() > 1) ? dut_grants[0] : 4'b0000), 64'h2);
    check_eq("wc_g1", 64'((dut_grants.size() > 1) ? dut_grants[1] : 4'b0000), 64'h8);

    // Memory never acks: timeout on port 0, then port 2 is served.
    dut_grants.delete();
    ack_mode = 0; rd_req[0] = 1'b1; rd_req[2] = 1'b1;
    run_until_idle(60);
    check_eq("to_err", 64'(last_done_err), 64'd1);
    check_eq("to_g1", 64'((dut_grants.size() > 1) ? dut_grants[1] : 4'b0000), 64'h4);

    // Port 0 asserts rd and wr together.
    ack_mode = 2; rd_req[0] = 1'b1; wr_req[0] = 1'b1;
    step();
    check_eq("rw_memreq", 64'({mem_read_req, mem_write_req}), 64'b01);
    run_until_idle(50);
    check_eq("rw_err", 64'(last_done_err), 64'd1);

    // Ack on the same cycle the timeout would fire.
    ack_mode = TMO + 1; data_fixed = 16'h1234; rd_req[1] = 1'b1;
    run_until_idle(50);
    check_eq("co_err", 64'(last_done_err), 64'd0);
    check_eq("co_rdata", 64'(rdata), 64'h1234);

    // Reset pulse in BUSY.
    ack_mode = 0; rd_req[1] = 1'b1;
    step(); step();
    check_eq("rb_pre_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1 check_zero("rb");
    rd_req = 4'b0000; wr_req = 4'b0000; mem_ack = 1'b0;
    cyc = 0; start = 1'b0; model_last = 3; model_rdata = 16'd0;
    @(negedge clk);
    check_zero("rb_hold");
    reset_n = 1'b1;
    dut_grants.delete();
    rd_req = 4'hF; ack_mode = 2;
    run_until_idle(100);
    check_eq("rb_first", 64'((dut_grants.size() > 0) ? dut_grants[0] : 4'b0000), 64'h1);

    // Randomized traffic with random latencies, drops and stray acks.
    data_fixed_en = 1'b0; noise_en = 1'b1; drop_en = 1'b1;
    ack_mode = -1; req_mode = 1;
    for (int s = 0; s < 600; s++) step();
    noise_en = 1'b0;
    run_until_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
